// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared types and lane helpers for the load/store unit.
// Optional feature macro used by the top: LSU_MISALIGN_CHECK_EN.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

    // Request attributes still needed after acceptance (load extract + store done path).
    typedef struct packed {
        logic      is_store;
        mem_size_t size;
        logic      load_unsigned;
        logic [1:0] off;
    } lsu_req_t;

    // Byte enables for a sub-word access. HALF keys off addr[1] only.
    function automatic logic [3:0] calc_be(input mem_size_t size, input logic [1:0] off);
        case (size)
            MEM_BYTE: calc_be = 4'b0001 << off;
            MEM_HALF: calc_be = off[1] ? 4'b1100 : 4'b0011;
            default:  calc_be = 4'hF;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables pick the right one.
    function automatic logic [31:0] calc_wdata(input mem_size_t size, input logic [31:0] data);
        case (size)
            MEM_BYTE: calc_wdata = {4{data[7:0]}};
            MEM_HALF: calc_wdata = {2{data[15:0]}};
            default:  calc_wdata = data;
        endcase
    endfunction

    // Natural-alignment test used when the misalignment check is built in.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        is_misaligned = ((size == MEM_HALF) && off[0]) ||
                        ((size == MEM_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/gnt/rvalid data-memory bus between the LSU and memory.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// lsu_load_align: pull the addressed byte/half out of the read word and extend it.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign/zero extend; WORD passes straight through.
    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access stage after the ALU.
// Optional: define LSU_MISALIGN_CHECK_EN to reject misaligned HALF/WORD accesses
// with a one-cycle done+misaligned pulse instead of issuing them.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_store,
    input  mem_size_t                mem_size,
    input  logic                     load_unsigned,
    input  logic [31:0]              addr,
    input  logic [31:0]              store_data,
    load_store_unit_if.master        mem,
    output logic                     done,
    output logic [31:0]              load_data,
    output logic                     bus_err,
    output logic                     misaligned
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] align_data;
    logic        limit_hit;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        mis_q, mis_d;
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign limit_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == T_LIM);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign done          = done_q;
    assign bus_err       = bus_err_q;
    assign load_data     = load_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned    = mis_q;
`else
    assign misaligned    = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata       (mem.mem_rdata),
        .off         (req_q.off),
        .size        (req_q.size),
        .is_unsigned (req_q.load_unsigned),
        .data        (align_data)
    );

    // Next-state and next-output logic; status pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        load_data_d = 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d = '{is_store: is_store, size: mem_size,
                              load_unsigned: load_unsigned, off: addr[1:0]};
`ifdef LSU_MISALIGN_CHECK_EN
                    if (is_misaligned(mem_size, addr[1:0])) begin
                        // Rejected without touching the bus; stay idle.
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end else
`endif
                    begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = calc_be(mem_size, addr[1:0]);
                        mem_wdata_d = calc_wdata(mem_size, store_data);
                    end
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    if (req_q.is_store) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (limit_hit) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    done_d      = 1'b1;
                    load_data_d = align_data;
                    state_d     = IDLE;
                end else if (limit_hit) begin
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight access silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            load_data_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of stores, loads, timeout and reset abort.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    mem_size_t   mem_size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        done;
    logic [31:0] load_data;
    logic        bus_err;
    logic        misaligned;
    int          errors = 0;
    int          checks = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .is_store      (is_store),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .store_data    (store_data),
        .mem           (mem_bus),
        .done          (done),
        .load_data     (load_data),
        .bus_err       (bus_err),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one accepting edge, then scramble the inputs.
    task automatic issue(input logic st, input mem_size_t sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; is_store = st; mem_size = sz; load_unsigned = uns;
        addr = a; store_data = d;
        tick();
        req_valid = 1'b0; is_store = ~st; mem_size = MEM_BYTE; load_unsigned = ~uns;
        addr = 32'hFFFF_FFFF; store_data = 32'h0;
    endtask

    // Load with gnt at T1 and rvalid gap cycles after gnt; returns in the done cycle.
    task automatic run_load(input mem_size_t sz, input logic uns, input logic [31:0] a,
                            input logic [31:0] rd, input int gap);
        issue(1'b0, sz, uns, a, 32'h0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        repeat (gap - 1) tick();
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = rd;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0BAD_0BAD;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; mem_size = MEM_BYTE;
        load_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_ready", req_ready, 0);
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_mem_we", mem_bus.mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);
        chk("rst_mem_be", mem_bus.mem_be, 0);
        chk("rst_mem_wdata", mem_bus.mem_wdata, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", req_ready, 1);

        // SW 0x100, gnt at T1, done at T2
        issue(1'b1, MEM_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF);
        chk("sw_mem_req", mem_bus.mem_req, 1);
        chk("sw_ready_busy", req_ready, 0);
        chk("sw_mem_addr", mem_bus.mem_addr, 32'h100);
        chk("sw_mem_be", mem_bus.mem_be, 4'hF);
        chk("sw_mem_we", mem_bus.mem_we, 1);
        chk("sw_mem_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("sw_done", done, 1);
        chk("sw_bus_err", bus_err, 0);
        chk("sw_misaligned", misaligned, 0);
        chk("sw_load_data", load_data, 0);
        chk("sw_mem_req_drop", mem_bus.mem_req, 0);
        chk("sw_ready_at_done", req_ready, 1);
        tick();
        chk("sw_done_pulse", done, 0);

        // SB 0x103, gnt held off one cycle
        issue(1'b1, MEM_BYTE, 1'b0, 32'h103, 32'h0000_00A5);
        tick();
        chk("sb_mem_req_held", mem_bus.mem_req, 1);
        chk("sb_mem_addr", mem_bus.mem_addr, 32'h100);
        chk("sb_mem_be", mem_bus.mem_be, 4'b1000);
        chk("sb_mem_wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("sb_done", done, 1);
        tick();

        // SH 0x102
        issue(1'b1, MEM_HALF, 1'b0, 32'h102, 32'h1234_BEEF);
        chk("sh_mem_be", mem_bus.mem_be, 4'b1100);
        chk("sh_mem_wdata", mem_bus.mem_wdata, 32'hBEEF_BEEF);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("sh_done", done, 1);
        tick();

        // rvalid while idle is ignored
        mem_bus.mem_rvalid = 1'b1;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        chk("idle_rvalid_done", done, 0);

        // LB / LBU at 0x202, rvalid 3 cycles after gnt
        run_load(MEM_BYTE, 1'b0, 32'h202, 32'h1280_FF34, 3);
        chk("lb_done", done, 1);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        chk("lb_bus_err", bus_err, 0);
        tick();
        chk("lb_done_pulse", done, 0);
        chk("lb_data_clear", load_data, 0);
        run_load(MEM_BYTE, 1'b1, 32'h202, 32'h1280_FF34, 3);
        chk("lbu_data", load_data, 32'h0000_0080);
        tick();

        // Minimum-latency loads (rvalid right after gnt)
        run_load(MEM_BYTE, 1'b0, 32'h200, 32'h1280_FF34, 1);
        chk("lb0_done", done, 1);
        chk("lb0_data", load_data, 32'h0000_0034);
        tick();
        run_load(MEM_BYTE, 1'b1, 32'h201, 32'h1280_FF34, 1);
        chk("lbu1_data", load_data, 32'h0000_00FF);
        tick();
        run_load(MEM_HALF, 1'b0, 32'h200, 32'h1280_FF34, 1);
        chk("lh0_data", load_data, 32'hFFFF_FF34);
        tick();

        // LH / LHU at 0x302
        run_load(MEM_HALF, 1'b0, 32'h302, 32'h8001_5A5A, 2);
        chk("lh_data", load_data, 32'hFFFF_8001);
        tick();
        run_load(MEM_HALF, 1'b1, 32'h302, 32'h8001_5A5A, 2);
        chk("lhu_data", load_data, 32'h0000_8001);
        tick();

        // LW
        run_load(MEM_WORD, 1'b0, 32'h400, 32'hCAFE_F00D, 1);
        chk("lw_done", done, 1);
        chk("lw_data", load_data, 32'hCAFE_F00D);
        tick();

        // Timeout in REQ: mem_req high 5 cycles, then bus_err
        issue(1'b1, MEM_WORD, 1'b0, 32'h500, 32'h1111_2222);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("to_mem_req_%0d", i), mem_bus.mem_req, 1);
            chk($sformatf("to_no_done_%0d", i), done, 0);
            tick();
        end
        chk("to_done", done, 1);
        chk("to_bus_err", bus_err, 1);
        chk("to_mem_req", mem_bus.mem_req, 0);
        chk("to_ready", req_ready, 1);
        chk("to_load_data", load_data, 0);
        tick();
        chk("to_bus_err_pulse", bus_err, 0);
        chk("to_done_pulse", done, 0);

        // gnt in the limit cycle wins over the timeout
        issue(1'b1, MEM_WORD, 1'b0, 32'h504, 32'h3333_4444);
        repeat (4) tick();
        chk("lim_mem_req", mem_bus.mem_req, 1);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("lim_done", done, 1);
        chk("lim_bus_err", bus_err, 0);
        tick();

        // Timeout in WAIT
        issue(1'b0, MEM_WORD, 1'b0, 32'h508, 32'h0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        repeat (4) tick();
        chk("tow_no_done", done, 0);
        tick();
        chk("tow_done", done, 1);
        chk("tow_bus_err", bus_err, 1);
        chk("tow_load_data", load_data, 0);
        tick();

        // Reset while in WAIT, late rvalid ignored
        issue(1'b0, MEM_WORD, 1'b0, 32'h600, 32'h0);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("rw_wait_mem_req", mem_bus.mem_req, 0);
        chk("rw_wait_ready", req_ready, 0);
        rst = 1'b1;
        tick();
        chk("rw_mem_req", mem_bus.mem_req, 0);
        chk("rw_done", done, 0);
        rst = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h7777_7777;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        chk("rw_late_rvalid_done", done, 0);
        chk("rw_idle_ready", req_ready, 1);
        tick();
        chk("rw_still_no_done", done, 0);

        // Store after reset still works
        issue(1'b1, MEM_WORD, 1'b0, 32'h700, 32'h0102_0304);
        chk("post_rst_addr", mem_bus.mem_addr, 32'h700);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        chk("post_rst_done", done, 1);
        tick();

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned LW is rejected without a bus request
        issue(1'b0, MEM_WORD, 1'b0, 32'h101, 32'h0);
        chk("mis_mem_req", mem_bus.mem_req, 0);
        chk("mis_done", done, 1);
        chk("mis_flag", misaligned, 1);
        chk("mis_load_data", load_data, 0);
        chk("mis_ready", req_ready, 1);
        tick();
        chk("mis_pulse", misaligned, 0);
        chk("mis_done_pulse", done, 0);
`else
        // Without the check a LW at 0x101 proceeds word-aligned
        issue(1'b0, MEM_WORD, 1'b0, 32'h101, 32'h0);
        chk("mw_mem_req", mem_bus.mem_req, 1);
        chk("mw_mem_addr", mem_bus.mem_addr, 32'h100);
        chk("mw_mem_be", mem_bus.mem_be, 4'hF);
        mem_bus.mem_gnt = 1'b1;
        tick();
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hA1B2_C3D4;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        chk("mw_done", done, 1);
        chk("mw_data", load_data, 32'hA1B2_C3D4);
        chk("mw_misaligned", misaligned, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
